// File: rtl/joybus_pkg.sv
// joybus_pkg: shared states, bit-cell timing constants and timing helper for the Joybus poll engine
package joybus_pkg;
    typedef enum logic [3:0] {
        IDLE, TX_LOW, TX_HIGH, TX_STOP_LOW, TX_STOP_HIGH,
        RX_WAIT_FALL, RX_LOW, RX_HIGH, RX_STOP, DONE
    } state_t;
    localparam int T_SHORT_US  = 1;
    localparam int T_LONG_US   = 3;
    localparam int T_SAMPLE_US = 2;
    localparam int T_CELL_US   = 4;
    function automatic int us_to_cycles(input int us, input int clk_per_us);
        return us * clk_per_us;
    endfunction
endpackage

// File: rtl/joybus_bit_tx.sv
// joybus_bit_tx: drives one Joybus bit cell (low phase then released phase) with end-of-phase strobes
module joybus_bit_tx import joybus_pkg::*; #(
    parameter int CLK_PER_US = 100
) (
    input  logic PCLK,
    input  logic reset,
    input  logic go,
    input  logic bit_val,
    output logic oe,
    output logic turn,
    output logic done
);
    localparam int SHORT = us_to_cycles(T_SHORT_US, CLK_PER_US);
    localparam int LONG  = us_to_cycles(T_LONG_US, CLK_PER_US);
    localparam int W     = $clog2(LONG);
    logic [W-1:0] cnt;
    logic         hi, active, val;
    // strobes fire in the last cycle of a phase so a following go makes cells back-to-back
    assign turn = active & ~hi & (cnt == '0);
    assign done = active & hi & (cnt == '0);
    always_ff @(posedge PCLK) begin
        if (reset) begin
            active <= 1'b0;
            hi     <= 1'b0;
            oe     <= 1'b0;
            val    <= 1'b0;
            cnt    <= '0;
        end else if (go) begin
            active <= 1'b1;
            hi     <= 1'b0;
            oe     <= 1'b1;
            val    <= bit_val;
            cnt    <= bit_val ? W'(SHORT - 1) : W'(LONG - 1);
        end else if (turn) begin
            hi  <= 1'b1;
            oe  <= 1'b0;
            cnt <= val ? W'(LONG - 1) : W'(SHORT - 1);
        end else if (done) begin
            active <= 1'b0;
            hi     <= 1'b0;
        end else if (active) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/joybus_poll_ctrl.sv
// joybus_poll_ctrl: sends a pad poll command on the open-drain line and captures the pad response
module joybus_poll_ctrl import joybus_pkg::*; #(
    parameter int                  CLK_PER_US     = 100,
    parameter int                  CMD_BITS       = 24,
    parameter logic [CMD_BITS-1:0] CMD_BASE       = 24'h400300,
    parameter int                  RSP_BITS       = 64,
    parameter int                  POLL_PERIOD_US = 6000,
    parameter int                  RSP_TIMEOUT_US = 100,
    parameter int                  BIT_TIMEOUT_US = 8
) (
    input  logic                PCLK,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic                rumble,
    input  logic                line_in,
    output logic                line_oe,
    output logic                busy,
    output logic [RSP_BITS-1:0] rsp_data,
    output logic                rsp_valid,
    output logic                rsp_error
);
    localparam int POLL_CYC = us_to_cycles(POLL_PERIOD_US, CLK_PER_US);
    localparam int RSP_CYC  = us_to_cycles(RSP_TIMEOUT_US, CLK_PER_US);
    localparam int BIT_CYC  = us_to_cycles(BIT_TIMEOUT_US, CLK_PER_US);
    localparam int SMP_CYC  = us_to_cycles(T_SAMPLE_US, CLK_PER_US);
    localparam int W        = $clog2(POLL_CYC);
    localparam int CW       = $clog2(CMD_BITS + 1);
    localparam int NW       = $clog2(RSP_BITS + 1);

    state_t              state;
    logic [2:0]          sync;
    logic [W-1:0]        pc, t, ph;
    logic [CMD_BITS-1:0] cmd_sh, cmd_load;
    logic [CW-1:0]       cmd_left;
    logic [RSP_BITS-1:0] rx_sh;
    logic [NW-1:0]       nbits;
    logic                lin, fall, rise, expired, launch;
    logic                tx_go, tx_bit, tx_turn, tx_done;
    logic                rx_st, wait_edge, rx_to, smp;

    assign cmd_load  = {CMD_BASE[CMD_BITS-1:1], rumble};
    assign lin       = sync[1];
    assign fall      = sync[2] & ~sync[1];
    assign rise      = ~sync[2] & sync[1];
    assign expired   = pc == W'(POLL_CYC - 1);
    assign launch    = (state == IDLE) & (start | (enable & expired));
    assign tx_go     = launch | (tx_done & (state == TX_HIGH));
    assign tx_bit    = (state == IDLE) ? cmd_load[CMD_BITS-1] :
                       (cmd_left == '0) ? 1'b1 : cmd_sh[CMD_BITS-1];
    assign rx_st     = (state == RX_WAIT_FALL) | (state == RX_LOW) |
                       (state == RX_HIGH) | (state == RX_STOP);
    assign wait_edge = ((state == RX_WAIT_FALL) | (state == RX_HIGH)) ? fall : rise;
    assign rx_to     = rx_st & ~wait_edge &
                       (ph == ((state == RX_WAIT_FALL) ? W'(RSP_CYC - 1) : W'(BIT_CYC - 1)));
    // sampling is timed from the fall, so a 1 is sampled after its rise
    assign smp       = ((state == RX_LOW) | (state == RX_HIGH)) &
                       (t == W'(SMP_CYC - 1)) & (nbits != NW'(RSP_BITS));

    joybus_bit_tx #(.CLK_PER_US(CLK_PER_US)) u_tx (
        .PCLK    (PCLK),
        .reset   (reset),
        .go      (tx_go),
        .bit_val (tx_bit),
        .oe      (line_oe),
        .turn    (tx_turn),
        .done    (tx_done)
    );

    always_ff @(posedge PCLK) begin
        if (reset) begin
            state     <= IDLE;
            sync      <= 3'b111;
            pc        <= '0;
            t         <= '0;
            ph        <= '0;
            cmd_sh    <= '0;
            cmd_left  <= '0;
            rx_sh     <= '0;
            nbits     <= '0;
            busy      <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
        end else begin
            sync      <= {sync[1:0], line_in};
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            pc        <= launch ? '0 : expired ? pc : pc + 1'b1;
            t         <= t + 1'b1;
            ph        <= ph + 1'b1;
            case (state)
                IDLE: if (launch) begin
                    state    <= TX_LOW;
                    busy     <= 1'b1;
                    cmd_sh   <= cmd_load << 1;
                    cmd_left <= CW'(CMD_BITS - 1);
                end
                TX_LOW:  if (tx_turn) state <= TX_HIGH;
                TX_HIGH: if (tx_done) begin
                    if (cmd_left != '0) begin
                        state    <= TX_LOW;
                        cmd_sh   <= cmd_sh << 1;
                        cmd_left <= cmd_left - 1'b1;
                    end else begin
                        state <= TX_STOP_LOW;
                    end
                end
                TX_STOP_LOW:  if (tx_turn) state <= TX_STOP_HIGH;
                TX_STOP_HIGH: if (tx_done) begin
                    state <= RX_WAIT_FALL;
                    ph    <= '0;
                    nbits <= '0;
                end
                RX_WAIT_FALL, RX_HIGH: if (fall) begin
                    state <= ((state == RX_HIGH) && (nbits == NW'(RSP_BITS))) ? RX_STOP : RX_LOW;
                    t     <= '0;
                    ph    <= '0;
                end
                RX_LOW: if (rise) begin
                    state <= RX_HIGH;
                    ph    <= '0;
                end
                RX_STOP: if (rise) state <= DONE;
                DONE: begin
                    state     <= IDLE;
                    rsp_data  <= rx_sh;
                    rsp_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (smp) begin
                rx_sh <= {rx_sh[RSP_BITS-2:0], lin};
                nbits <= nbits + 1'b1;
            end
            if (rx_to) begin
                state     <= IDLE;
                rsp_error <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_joybus_poll_ctrl.sv
// tb_joybus_poll_ctrl: directed vector table plus hand sequences against a scaled-timing poll engine
module tb_joybus_poll_ctrl;
    localparam int C        = 10;
    localparam int POLL_US  = 500;
    localparam int POLL_CYC = POLL_US * C;
    localparam int RSP_CYC  = 100 * C;
    localparam int GOOD = 0, NONE = 1, SHORT = 2;

    typedef struct {
        logic        rmb;
        int          mode;
        logic [63:0] resp;
        logic        ok;
        logic [63:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, start = 1'b0, rumble = 1'b0, pad_low = 1'b0;
    logic        line_in, line_oe, busy, rsp_valid, rsp_error;
    logic [63:0] rsp_data;
    int          n_cmp = 0, n_fail = 0, cyc = 0, nval = 0, nerr = 0;
    vec_t        vecs[5];

    assign line_in = ~(line_oe | pad_low);
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    joybus_poll_ctrl #(.CLK_PER_US(C), .POLL_PERIOD_US(POLL_US)) dut (
        .PCLK      (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .rumble    (rumble),
        .line_in   (line_in),
        .line_oe   (line_oe),
        .busy      (busy),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_error (rsp_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        if (rsp_valid) nval++;
        if (rsp_error) nerr++;
        @(negedge clk);
    endtask

    task automatic wait_busy(input logic v, input int lim);
        int n = 0;
        while (busy !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pad_send(input logic [63:0] resp, input int nb, input logic stop);
        for (int i = 63; i > 63 - nb; i--) begin
            pad_low = 1'b1;
            repeat (resp[i] ? C : 3 * C) step();
            pad_low = 1'b0;
            repeat (resp[i] ? 3 * C : C) step();
        end
        if (stop) begin
            pad_low = 1'b1;
            repeat (C) step();
            pad_low = 1'b0;
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [23:0] cmd;
        logic [24:0] bits;
        int          bad, nbusy, wait_n;
        cmd  = 24'h400300;
        bits = {cmd[23:1], v.rmb, 1'b1};
        rumble = v.rmb;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad   = 0;
        nbusy = 0;
        for (int i = 24; i >= 0; i--) begin
            for (int k = 0; k < 4 * C; k++) begin
                if (line_oe !== (k < (bits[i] ? C : 3 * C))) bad++;
                if (busy !== 1'b1) nbusy++;
                @(negedge clk);
            end
        end
        chk("tx_wave_bad_cycles", bad, 0);
        chk("tx_busy_low_cycles", nbusy, 0);
        nval = 0;
        nerr = 0;
        if (v.mode != NONE) begin
            repeat (3 * C) step();
            pad_send(v.resp, v.mode == GOOD ? 64 : 10, v.mode == GOOD);
        end
        wait_n = 0;
        while (nval == 0 && nerr == 0 && wait_n < 3000) begin
            step();
            wait_n++;
        end
        if (v.mode == NONE)
            chk("rx_timeout_in_window", (wait_n - 1 >= RSP_CYC - 3) && (wait_n - 1 <= RSP_CYC + 3), 1);
        repeat (20) step();
        chk("rsp_valid_pulses", nval, v.ok ? 1 : 0);
        chk("rsp_error_pulses", nerr, v.ok ? 0 : 1);
        chk("rsp_data", rsp_data, v.data);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int t1, t2;
        vecs[0] = '{1'b0, GOOD,  64'h0080_8080_8080_0000, 1'b1, 64'h0080_8080_8080_0000};
        vecs[1] = '{1'b1, GOOD,  64'hFFFF_0000_A5A5_1234, 1'b1, 64'hFFFF_0000_A5A5_1234};
        vecs[2] = '{1'b0, NONE,  64'h0,                   1'b0, 64'hFFFF_0000_A5A5_1234};
        vecs[3] = '{1'b1, SHORT, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_0000_A5A5_1234};
        vecs[4] = '{1'b0, GOOD,  64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001};

        repeat (3) @(negedge clk);
        chk("reset_line_oe", line_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_error", rsp_error, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
            repeat (10) @(negedge clk);
        end

        // reset while the command is driving the line low
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midtx_oe_before", line_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midtx_rst_oe", line_oe, 0);
        chk("midtx_rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // reset in the middle of the pad response
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100 * C + 3 * C) @(negedge clk);
        nval = 0;
        nerr = 0;
        pad_send(64'hF0F0_0000_0000_0000, 5, 1'b0);
        pad_low = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        chk("midrx_rst_oe", line_oe, 0);
        chk("midrx_rst_busy", busy, 0);
        chk("midrx_rst_valid", rsp_valid, 0);
        reset   = 1'b0;
        pad_low = 1'b0;
        repeat (200) step();
        chk("midrx_no_pulses", nval + nerr, 0);
        chk("midrx_data_cleared", rsp_data, 0);
        run_txn(vecs[0]);

        // auto polling period, ignored start while busy, immediate start when already expired
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        wait_busy(1'b1, POLL_CYC + 100);
        t1 = cyc;
        chk("auto_first_start", busy, 1);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_busy(1'b0, 4000);
        chk("auto_first_end", busy, 0);
        wait_busy(1'b1, POLL_CYC + 100);
        t2 = cyc;
        chk("auto_period_cycles", t2 - t1, POLL_CYC);
        enable = 1'b0;
        wait_busy(1'b0, 4000);
        while (cyc - t2 < POLL_CYC + 50) @(negedge clk);
        chk("expired_idle", busy, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_immediate", busy, 1);
        enable = 1'b0;
        wait_busy(1'b0, 4000);
        chk("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/joybus_poll_ctrl.md
Name: joybus_poll_ctrl

Overview:
Parametrised Joybus (GameCube pad) poll engine: serialises a CMD_BITS command plus stop bit on the open-drain data line, then releases the line and deserialises the pad's RSP_BITS response. It adds a rumble-mode bit, response capture, timeout/error detection, and both periodic and one-shot polling. It sits between the pad pin (external open-drain pad cell) and the button-decode logic.

Parameters:
CLK_PER_US, 100, PCLK cycles per microsecond; all timing derives from it.
CMD_BITS, 24, command length in bits, sent MSB first.
CMD_BASE, 24'h400300, command word; bit 0 is replaced by the rumble input.
RSP_BITS, 64, response length in bits.
POLL_PERIOD_US, 6000, start-to-start interval in auto mode.
RSP_TIMEOUT_US, 100, maximum wait from end of stop bit to the first response falling edge.
BIT_TIMEOUT_US, 8, maximum low or high phase inside the response.

Ports:
PCLK  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  auto mode: poll every POLL_PERIOD_US while high
start  in  1  one-shot request; honoured only in IDLE
rumble  in  1  sampled at transaction start; drives command bit 0
line_in  in  1  raw data-line level (asynchronous)
line_oe  out  1  1 = pull line low; 0 = release (pull-up gives high)
busy  out  1  transaction in progress
rsp_data  out  RSP_BITS  last good response, MSB = first bit received
rsp_valid  out  1  one-cycle pulse when rsp_data updates
rsp_error  out  1  one-cycle pulse on timeout or short response

Behaviour:
- Reset: line_oe=0, busy=0, rsp_data=0, rsp_valid=0, rsp_error=0, state IDLE, period counter 0. Reset mid-transaction releases the line on the next edge; no partial result is published.
- line_in passes through a 2-flop synchroniser; fall/rise detection is on the synchronised signal, so response edge latency is 2-3 cycles.
- Encoding: the bit cell is 4 us. A 0 is low 3 us, then high 1 us. A 1 is low 1 us, then high 3 us. The stop bit is 1. Phases are exact cycle counts (for example 300/100 at CLK_PER_US=100).
- States: IDLE -> TX_LOW -> TX_HIGH (repeat per bit) -> TX_STOP_LOW -> TX_STOP_HIGH -> RX_WAIT_FALL -> RX_LOW -> RX_HIGH (repeat) -> RX_STOP -> DONE -> IDLE.
- Start: from IDLE on (start) or (enable and period counter expired). line_oe=1 on the next edge. Command shift register is loaded with {CMD_BASE[CMD_BITS-1:1], rumble}; busy=1.
- After TX_STOP_HIGH, line_oe stays 0 for the rest of the transaction.
- RX_WAIT_FALL: timeout after RSP_TIMEOUT_US -> error.
- RX_LOW: sample line at 2 us after the fall; low => 0, high => 1; shift in MSB first.
  - If low persists beyond BIT_TIMEOUT_US -> error.
  - If high lasts past BIT_TIMEOUT_US before all RSP_BITS are received -> error (short response).
- RX_STOP: after RSP_BITS bits, wait for the pad stop bit (fall then rise, each bounded by BIT_TIMEOUT_US); any timeout -> error.
- DONE: rsp_data <= shift register, rsp_valid pulse, busy=0.
- Error path: rsp_error pulse, rsp_data unchanged, busy=0, return to IDLE.
- Period counter:
  - Free-runs from each transaction start; it expires at POLL_PERIOD_US*CLK_PER_US-1 and saturates until a transaction starts.
  - If enable rises while the counter is expired, the poll starts immediately.
  - If a transaction is still busy at expiry, the next poll starts on return to IDLE.
- start while busy is ignored (not queued). start and expiry in the same cycle launch one transaction.
- Counter widths: use $clog2 of the largest count, POLL_PERIOD_US*CLK_PER_US.

Decomposition:
- Package joybus_pkg holds:
  - the state enum;
  - the timing constants T_SHORT_US=1, T_LONG_US=3, T_SAMPLE_US=2, T_CELL_US=4;
  - a function us_to_cycles.
- One sub-module, joybus_bit_tx: given a bit and a go pulse, it produces the low/high phases and a done pulse. It is also reused for the stop bit.
- Receive logic and the FSM stay in the top module.

Test Plan:
- Reset, then start=1 for one cycle, rumble=0 -> line_oe sequence matches 0x400300 encoding plus stop. First bit: 300 cycles high (driven low), then 100 released. busy=1 throughout.
- rumble=1 -> last command bit cell is oe=1 for 100 cycles, then 0 for 300.
- Pad model replies with 64-bit 0x0080_8080_8080_0000 plus stop -> rsp_data equals that value, rsp_valid pulses once, rsp_error=0.
- No reply (line held high) -> rsp_error pulses RSP_TIMEOUT_US*100 cycles after the stop bit (±3 cycles); rsp_data retains its previous value.
- enable=1 held -> transaction starts are exactly 600000 cycles apart; a start pulse while busy produces no extra transaction.
- reset asserted mid-response -> next cycle line_oe=0, busy=0, no rsp_valid. A fresh poll afterwards succeeds.
